// File: rtl/spart_bus_arbiter_if.sv
// spart_bus_arbiter_if: SPART control strobes, ready flags and the two client handshakes
// master: arbiter side (drives iocs/iorw/ioaddr, done/rdata, cfg_done; reads rda/tbr and client requests)
// slave: SPART model plus clients (drives rda/tbr, req/op/wdata; reads the rest)
interface spart_bus_arbiter_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  logic       req0;
  logic       req1;
  logic       op0;
  logic       op1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       done0;
  logic       done1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic       cfg_done;
  modport master (
    output iocs, iorw, ioaddr, done0, done1, rdata0, rdata1, cfg_done,
    input  rda, tbr, req0, req1, op0, op1, wdata0, wdata1
  );
  modport slave (
    input  iocs, iorw, ioaddr, done0, done1, rdata0, rdata1, cfg_done,
    output rda, tbr, req0, req1, op0, op1, wdata0, wdata1
  );
endinterface

// File: rtl/spart_bus_arbiter.sv
// spart_bus_arbiter: programs the SPART baud divisor and round-robin shares its bus between two clients
// clk/rst: clock, asynchronous active-high reset; br_cfg: baud select
// databus: SPART data bus, driven only on write strobes; bus: control strobes and client handshakes
module spart_bus_arbiter #(
  parameter logic [15:0] DB_0 = 16'h0515,
  parameter logic [15:0] DB_1 = 16'h028A,
  parameter logic [15:0] DB_2 = 16'h0145,
  parameter logic [15:0] DB_3 = 16'h00A2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  inout  wire  [7:0] databus,
  spart_bus_arbiter_if.master bus
);
  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, WAIT, ACCESS, DONE} state_t;
  state_t     r_state, w_next;
  logic [1:0] r_br_cfg_q;
  logic       r_last, r_grant, r_op, r_cfg_done;
  logic [7:0] r_wdata, r_rdata0, r_rdata1;
  logic [15:0] w_db;
  logic       w_cfg_chg, w_pick, w_req_g, w_ready, w_cyc, w_drive;
  logic [7:0] w_out;
  assign w_db = r_br_cfg_q == 2'd0 ? DB_0 : r_br_cfg_q == 2'd1 ? DB_1 :
                r_br_cfg_q == 2'd2 ? DB_2 : DB_3;
  assign w_cfg_chg = br_cfg != r_br_cfg_q;
  // a lone requester wins outright; on a tie the client that did not finish last wins
  assign w_pick  = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
  assign w_req_g = r_grant ? bus.req1 : bus.req0;
  assign w_ready = r_op ? bus.rda : bus.tbr;
  always_comb begin
    w_next = r_state;
    case (r_state)
      CFG_LO: w_next = CFG_HI;
      CFG_HI: w_next = IDLE;
      IDLE:   w_next = w_cfg_chg ? CFG_LO : (bus.req0 || bus.req1) ? WAIT : IDLE;
      WAIT:   w_next = !w_req_g ? IDLE : w_ready ? ACCESS : WAIT;
      ACCESS: w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = CFG_LO;
    endcase
  end
  // rst gates the strobes so the reset state (CFG_LO) is not presented while reset is held
  assign w_cyc   = !rst && (r_state == CFG_LO || r_state == CFG_HI || r_state == ACCESS);
  assign w_drive = w_cyc && !(r_state == ACCESS && r_op);
  assign w_out   = r_state == CFG_LO ? w_db[7:0] : r_state == CFG_HI ? w_db[15:8] : r_wdata;
  assign databus = w_drive ? w_out : 8'hzz;
  assign bus.iocs     = w_cyc;
  assign bus.iorw     = !w_drive;
  assign bus.ioaddr   = !w_cyc ? 2'b00 : r_state == CFG_LO ? 2'b10 : r_state == CFG_HI ? 2'b11 : 2'b00;
  assign bus.done0    = r_state == DONE && !r_grant;
  assign bus.done1    = r_state == DONE && r_grant;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign bus.cfg_done = r_cfg_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CFG_LO;
      r_br_cfg_q <= br_cfg;
      r_last     <= 1'b1;
      r_grant    <= 1'b0;
      r_op       <= 1'b0;
      r_wdata    <= 8'h00;
      r_rdata0   <= 8'h00;
      r_rdata1   <= 8'h00;
      r_cfg_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_cfg_chg) begin
        r_br_cfg_q <= br_cfg;
        r_cfg_done <= 1'b0;
      end
      if (r_state == CFG_HI) r_cfg_done <= 1'b1;
      if (r_state == IDLE && !w_cfg_chg && (bus.req0 || bus.req1)) begin
        r_grant <= w_pick;
        r_op    <= w_pick ? bus.op1 : bus.op0;
        r_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == ACCESS && r_op) begin
        if (r_grant) r_rdata1 <= databus;
        else r_rdata0 <= databus;
      end
      if (r_state == DONE) r_last <= r_grant;
    end
  end
endmodule

// File: tb/tb_spart_bus_arbiter.sv
// tb_spart_bus_arbiter: scoreboard bench; driver queues expected SPART accesses and done pulses, monitor checks them
module tb_spart_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic [7:0] rd_byte = 8'h00;
  logic rnd_en = 1'b0;
  wire  [7:0] databus;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [10:0] exp_acc[$];
  logic [16:0] exp_done[$];
  logic [7:0] m_rd[2];
  logic m_last;
  spart_bus_arbiter_if bus();
  spart_bus_arbiter dut (.clk(clk), .rst(rst), .br_cfg(br_cfg), .databus(databus), .bus(bus));
  assign databus = (bus.iocs && bus.iorw) ? rd_byte : 8'hzz;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] dbv(input logic [1:0] c);
    return c == 2'd0 ? 16'h0515 : c == 2'd1 ? 16'h028A : c == 2'd2 ? 16'h0145 : 16'h00A2;
  endfunction
  task automatic push_cfg(input logic [1:0] c);
    logic [15:0] d;
    d = dbv(c);
    exp_acc.push_back({1'b0, 2'b10, d[7:0]});
    exp_acc.push_back({1'b0, 2'b11, d[15:8]});
  endtask
  task automatic push_txn(input bit c, input bit op, input logic [7:0] wd, input logic [7:0] rb);
    exp_acc.push_back({op, 2'b00, op ? rb : wd});
    if (op) m_rd[c] = rb;
    exp_done.push_back({c, m_rd[0], m_rd[1]});
    m_last = c;
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.iocs) begin
        if (exp_acc.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL access_unexpected: got iorw=%b ioaddr=%b data=%h, required no access (cycle %0d)",
                   bus.iorw, bus.ioaddr, databus, cyc);
        end else chk("access", {bus.iorw, bus.ioaddr, databus}, exp_acc.pop_front());
      end
      if (bus.done0 || bus.done1) begin
        chk("done_exclusive", bus.done0 & bus.done1, 0);
        if (exp_done.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_unexpected: got done0=%b done1=%b, required no done (cycle %0d)",
                   bus.done0, bus.done1, cyc);
        end else chk("done", {bus.done1, bus.rdata0, bus.rdata1}, exp_done.pop_front());
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_en) begin
      bus.tbr = 1'($urandom_range(0, 1));
      bus.rda = 1'($urandom_range(0, 1));
    end
  end
  task automatic wait_done(input bit c, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(c ? bus.done1 : bus.done0) && n < 300);
  endtask
  task automatic set_req(input bit c, input bit v);
    if (c) bus.req1 = v;
    else bus.req0 = v;
  endtask
  task automatic txn(input bit c, input bit op, input logic [7:0] wd, input logic [7:0] rb, output int lat);
    push_txn(c, op, wd, rb);
    rd_byte = rb;
    if (c) begin bus.op1 = op; bus.wdata1 = wd; end
    else begin bus.op0 = op; bus.wdata0 = wd; end
    @(posedge clk);
    #1 set_req(c, 1'b1);
    wait_done(c, lat);
    chk("txn_done_seen", c ? bus.done1 : bus.done0, 1);
    set_req(c, 1'b0);
  endtask
  task automatic chk_reset();
    @(negedge clk);
    chk("rst_iocs", bus.iocs, 0);
    chk("rst_iorw", bus.iorw, 1);
    chk("rst_ioaddr", bus.ioaddr, 0);
    chk("rst_done", {bus.done0, bus.done1}, 0);
    chk("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
    chk("rst_cfg_done", bus.cfg_done, 0);
  endtask
  task automatic release_rst();
    m_rd[0] = 8'h00;
    m_rd[1] = 8'h00;
    m_last = 1'b1;
    push_cfg(br_cfg);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("cfg_done_c1", bus.cfg_done, 0);
    @(negedge clk);
    chk("cfg_done_c2", bus.cfg_done, 0);
    @(negedge clk);
    chk("cfg_done_c3", bus.cfg_done, 1);
    chk("iocs_after_cfg", bus.iocs, 0);
  endtask
  task automatic contend();
    int t[4];
    int k = 0;
    int n = 0;
    logic g;
    bus.op0 = 1'b0;
    bus.op1 = 1'b0;
    bus.wdata0 = 8'hA0;
    bus.wdata1 = 8'hB1;
    bus.tbr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = ~m_last;
      push_txn(g, 1'b0, g ? 8'hB1 : 8'hA0, 8'h00);
    end
    @(posedge clk);
    #1 bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.done0 || bus.done1) begin
        t[k] = n;
        k++;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("contend_done_count", k, 4);
    for (int i = 1; i < 4; i++) chk("contend_spacing", t[i] - t[i-1], 4);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lat, low;
    bit c, op;
    logic [1:0] nb;
    bus.rda = 1'b0; bus.tbr = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = 1'b0; bus.op1 = 1'b0;
    bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    repeat (2) @(posedge clk);
    chk_reset();
    release_rst();
    push_txn(1'b0, 1'b0, 8'h41, 8'h00);
    bus.op0 = 1'b0;
    bus.wdata0 = 8'h41;
    @(posedge clk);
    #1 bus.req0 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("iocs_while_tbr0", bus.iocs, 0);
    end
    bus.tbr = 1'b1;
    wait_done(1'b0, lat);
    chk("tbr_to_done", lat, 2);
    bus.req0 = 1'b0;
    txn(1'b0, 1'b0, 8'h33, 8'h00, lat);
    chk("latency_tx", lat, 4);
    bus.rda = 1'b1;
    txn(1'b1, 1'b1, 8'h00, 8'h5A, lat);
    chk("latency_rx", lat, 4);
    contend();
    bus.tbr = 1'b0;
    push_txn(1'b0, 1'b0, 8'h7E, 8'h00);
    push_cfg(2'b11);
    bus.op0 = 1'b0;
    bus.wdata0 = 8'h7E;
    @(posedge clk);
    #1 bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    br_cfg = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("no_cfg_while_wait", bus.iocs, 0);
    end
    bus.tbr = 1'b1;
    wait_done(1'b0, lat);
    chk("deferred_done_seen", bus.done0, 1);
    bus.req0 = 1'b0;
    low = 0;
    repeat (6) begin
      @(negedge clk);
      if (!bus.cfg_done) low++;
    end
    chk("cfg_done_low_cycles", low, 2);
    rnd_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        nb = 2'($urandom_range(0, 3));
        if (nb != br_cfg) begin
          push_cfg(nb);
          br_cfg = nb;
        end
      end
      c = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      txn(c, op, 8'($urandom), 8'($urandom), lat);
    end
    rnd_en = 1'b0;
    bus.rda = 1'b1;
    txn(1'b1, 1'b1, 8'h00, 8'hC3, lat);
    bus.tbr = 1'b0;
    bus.op0 = 1'b0;
    bus.wdata0 = 8'h99;
    @(posedge clk);
    #1 bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    bus.tbr = 1'b1;
    repeat (6) @(negedge clk);
    chk("drop_no_done", exp_done.size(), 0);
    contend();
    bus.tbr = 1'b0;
    bus.op1 = 1'b0;
    bus.wdata1 = 8'h55;
    @(posedge clk);
    #1 bus.req1 = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    bus.req1 = 1'b0;
    bus.tbr = 1'b1;
    chk_reset();
    release_rst();
    contend();
    repeat (4) @(negedge clk);
    chk("acc_queue_empty", exp_acc.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
